sort_job_arbiter: RTL

- Shares one 8-entry byte sorter core (`sorting`) between two requesters, A and B, using round-robin arbitration.
- For each accepted job the block:
  - latches the 8 input bytes;
  - clears the sorter through its reset;
  - drives the sorter's ready input until the sorter raises done;
  - captures the sorted result into a per-requester result buffer, delivered with a valid/ready handshake.
- Sits between the Lab04 host-side request logic and the sorter instance.

---
 rtl/sort_job_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sort_job_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one 8-byte sorter core between requesters A and B.
// Each job clears the sorter, runs it until done, and parks the result per requester.
module sort_job_arbiter #(
    parameter int CLR_CYCLES = 1,
    parameter int MAX_WAIT   = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req_valid,
    input  logic [63:0] a_req_data,
    output logic        a_req_ready,
    output logic        a_res_valid,
    output logic [63:0] a_res_data,
    input  logic        a_res_ready,
    input  logic        b_req_valid,
    input  logic [63:0] b_req_data,
    output logic        b_req_ready,
    output logic        b_res_valid,
    output logic [63:0] b_res_data,
    input  logic        b_res_ready,
    output logic        srt_rst_n,
    output logic        srt_ready,
    output logic [63:0] srt_data_in,
    input  logic [63:0] srt_data_out,
    input  logic        srt_done,
    output logic        busy,
    output logic        err
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [1:0]    clr_cnt_reg;
    logic [WW-1:0] wait_cnt_reg;
    logic          owner_reg;
    logic          prio_b_reg;
    logic          err_reg;
    logic [63:0]   job_reg;

    logic [1:0]    req_valid_v;
    logic [1:0]    res_ready_v;
    logic [1:0]    res_valid_v;
    logic [63:0]   res_data_v [2];
    logic [1:0]    elig;
    logic [1:0]    grant;
    logic          capture;
    logic          abort;
    logic          clr_active;
    logic          run_ready;

    assign req_valid_v = {b_req_valid, a_req_valid};
    assign res_ready_v = {b_res_ready, a_res_ready};
    // A requester with an unconsumed result may not start another job.
    assign elig        = req_valid_v & ~res_valid_v;

    always_comb begin
        state_next = state_reg;
        grant      = 2'b00;
        capture    = 1'b0;
        abort      = 1'b0;
        clr_active = 1'b0;
        run_ready  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (elig == 2'b11)
                    grant = prio_b_reg ? 2'b10 : 2'b01;
                else
                    grant = elig;
                if (grant != 2'b00)
                    state_next = CLR;
            end
            CLR: begin
                clr_active = 1'b1;
                if (clr_cnt_reg == 2'(CLR_CYCLES - 1))
                    state_next = RUN;
            end
            RUN: begin
                if (srt_done) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end else begin
                    run_ready = 1'b1;
                    if (wait_cnt_reg == WW'(MAX_WAIT - 1)) begin
                        abort      = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            clr_cnt_reg  <= 2'd0;
            wait_cnt_reg <= '0;
            owner_reg    <= 1'b0;
            prio_b_reg   <= 1'b0;
            err_reg      <= 1'b0;
            job_reg      <= 64'd0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= (state_reg == CLR && state_next == CLR) ? clr_cnt_reg + 2'd1 : 2'd0;
            wait_cnt_reg <= (state_reg == RUN && state_next == RUN) ? wait_cnt_reg + WW'(1) : '0;
            if (grant != 2'b00) begin
                job_reg    <= grant[1] ? b_req_data : a_req_data;
                owner_reg  <= grant[1];
                // Whoever was just served loses the next tie.
                prio_b_reg <= grant[0];
            end
            if (abort)
                err_reg <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_res
        logic        valid_reg;
        logic [63:0] data_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                data_reg  <= 64'd0;
            end else if (capture && owner_reg == 1'(gi)) begin
                valid_reg <= 1'b1;
                data_reg  <= srt_data_out;
            end else if (res_ready_v[gi]) begin
                valid_reg <= 1'b0;
            end
        end

        assign res_valid_v[gi] = valid_reg;
        assign res_data_v[gi]  = data_reg;
    end

    assign a_req_ready = grant[0];
    assign b_req_ready = grant[1];
    assign a_res_valid = res_valid_v[0];
    assign b_res_valid = res_valid_v[1];
    assign a_res_data  = res_data_v[0];
    assign b_res_data  = res_data_v[1];
    assign srt_rst_n   = rst_n & ~clr_active;
    assign srt_ready   = run_ready;
    assign srt_data_in = job_reg;
    assign busy        = (state_reg != IDLE);
    assign err         = err_reg;

endmodule
